// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the accumulator ALU (alu_acc_seq).
//   op_t     : 3-bit operation codes as presented on the op input
//   state_t  : sequencer states
//   HEX_SEG  : 7-segment patterns for hex digits 0..F, active-high, {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_ASR = 3'b110,
    OP_CLR = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/alu_acc_seq_hex7seg.sv
// -----------------------------------------------------------------------------
// hex7seg
// Combinational hex-digit to 7-segment decoder (active-high, {g,f,e,d,c,b,a}).
// Ports:
//   i_nib  in  4  hex digit
//   o_seg  out 7  segment pattern
// -----------------------------------------------------------------------------
module hex7seg
  import alu_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  // Table lookup of the segment pattern
  always_comb begin
    o_seg = HEX_SEG[i_nib];
  end

endmodule

// File: rtl/alu_acc_seq.sv
// -----------------------------------------------------------------------------
// alu_acc_seq
// NBITS-wide signed ALU with accumulator, start/done handshake, multi-cycle
// shift-add multiply, optional saturation and sticky overflow.
// Ports:
//   clk_2       in   clock                      reset      in   async, active-high
//   start       in   request (taken in IDLE)    op         in   3-bit op code (op_t)
//   a, b        in   signed operands            use_acc    in   A := accumulator
//   sat_en      in   clamp ADD/SUB/MUL on ovf   busy       out  operation in progress
//   done        out  one-cycle completion pulse result     out  accumulator
//   ovf         out  overflow of last op        ovf_sticky out  OR of ovf since reset/CLR
//   zero, neg   out  result flags               SEG        out  {ovf_sticky, hex(result[3:0])}
// -----------------------------------------------------------------------------
module alu_acc_seq
  import alu_pkg::*;
#(
  parameter int NBITS   = 8,
  parameter bit SAT_DEF = 1'b0
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic             use_acc,
  input  logic             sat_en,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] result,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic             zero,
  output logic             neg,
  output logic [7:0]       SEG
);

  localparam int PW  = 2 * NBITS;
  localparam int SHW = $clog2(NBITS);
  localparam int CW  = $clog2(NBITS + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(NBITS);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [NBITS-1:0] MAX_V    = {1'b0, {(NBITS-1){1'b1}}};
  localparam logic [NBITS-1:0] MIN_V    = {1'b1, {(NBITS-1){1'b0}}};

  state_t           r_state;
  state_t           w_state_nxt;
  op_t              r_op;
  logic [NBITS-1:0] r_a;
  logic [NBITS-1:0] r_b;
  logic [NBITS-1:0] r_acc;
  logic             r_sat;
  logic             r_ovf;
  logic             r_sticky;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_prod;
  logic [PW-1:0]    r_mcand;
  logic [NBITS-1:0] r_mplier;

  logic             w_accept;
  logic [NBITS-1:0] w_a_in;
  logic [NBITS-1:0] w_mag_a_in;
  logic [NBITS-1:0] w_mag_b_in;
  logic [NBITS-1:0] w_sum;
  logic [NBITS-1:0] w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic             w_msign;
  logic [PW-1:0]    w_prod_s;
  logic [NBITS:0]   w_mul_top;
  logic             w_mul_ovf;
  logic [NBITS-1:0] w_res;
  logic             w_ovf;
  logic [6:0]       w_seg;

  assign w_accept = (r_state == ST_IDLE) && start;

  // Operand selection and magnitudes for the multiplier, taken from the live inputs at accept
  always_comb begin
    w_a_in     = use_acc ? r_acc : a;
    w_mag_a_in = w_a_in[NBITS-1] ? (-w_a_in) : w_a_in;
    w_mag_b_in = b[NBITS-1] ? (-b) : b;
  end

  // Single-cycle arithmetic and multiply post-processing on the captured operands
  always_comb begin
    w_sum     = r_a + r_b;
    w_diff    = r_a - r_b;
    w_add_ovf = (r_a[NBITS-1] == r_b[NBITS-1]) && (w_sum[NBITS-1] != r_a[NBITS-1]);
    w_sub_ovf = (r_a[NBITS-1] != r_b[NBITS-1]) && (w_diff[NBITS-1] != r_a[NBITS-1]);
    w_msign   = r_a[NBITS-1] ^ r_b[NBITS-1];
    w_prod_s  = w_msign ? (-r_prod) : r_prod;
    // Product fits in NBITS signed only if the upper half plus the result sign bit agree
    w_mul_top = w_prod_s[PW-1:NBITS-1];
    w_mul_ovf = ~((&w_mul_top) | (~|w_mul_top));
  end

  // Result / overflow selection; on saturation the clamp follows the sign of the true result
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (r_op)
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_ADD: begin
        w_ovf = w_add_ovf;
        if (w_add_ovf && r_sat) w_res = r_a[NBITS-1] ? MIN_V : MAX_V;
        else                    w_res = w_sum;
      end
      OP_SUB: begin
        w_ovf = w_sub_ovf;
        if (w_sub_ovf && r_sat) w_res = r_a[NBITS-1] ? MIN_V : MAX_V;
        else                    w_res = w_diff;
      end
      OP_MUL: begin
        w_ovf = w_mul_ovf;
        if (w_mul_ovf && r_sat) w_res = w_msign ? MIN_V : MAX_V;
        else                    w_res = w_prod_s[NBITS-1:0];
      end
      OP_ASR: w_res = $signed(r_a) >>> r_b[SHW-1:0];
      OP_CLR: w_res = '0;
      default: begin
        w_res = '0;
        w_ovf = 1'b0;
      end
    endcase
  end

  // Next-state logic; MUL stays NBITS+1 cycles (NBITS add steps, then sign/exit)
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = (op == OP_MUL) ? ST_MUL : ST_EXEC;
        else       w_state_nxt = ST_IDLE;
      end
      ST_EXEC: w_state_nxt = ST_DONE;
      ST_MUL: begin
        if (r_cnt == CNT_LAST) w_state_nxt = ST_DONE;
        else                   w_state_nxt = ST_MUL;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register with registered busy/done derived from the next state
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Operand capture, shift-add multiply steps and accumulator/flag update
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_op     <= OP_AND;
      r_a      <= '0;
      r_b      <= '0;
      r_sat    <= SAT_DEF;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op     <= op_t'(op);
        r_a      <= w_a_in;
        r_b      <= b;
        r_sat    <= sat_en;
        r_cnt    <= '0;
        r_prod   <= '0;
        r_mcand  <= {{NBITS{1'b0}}, w_mag_a_in};
        r_mplier <= w_mag_b_in;
      end else if ((r_state == ST_MUL) && (r_cnt != CNT_LAST)) begin
        if (r_mplier[0]) r_prod <= r_prod + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_ONE;
      end
      if (w_state_nxt == ST_DONE) begin
        r_acc    <= w_res;
        r_ovf    <= w_ovf;
        r_sticky <= (r_op == OP_CLR) ? 1'b0 : (r_sticky | w_ovf);
      end
    end
  end

  hex7seg u_hex7seg (
    .i_nib (4'(r_acc)),
    .o_seg (w_seg)
  );

  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_acc;
  assign ovf        = r_ovf;
  assign ovf_sticky = r_sticky;
  assign zero       = (r_acc == '0);
  assign neg        = r_acc[NBITS-1];
  assign SEG        = {r_sticky, w_seg};

endmodule
